// File: rtl/mriscv_pkg.sv
// Shared encodings for the memory-access stage: mem_op, funct3 widths and FSM states.
package mriscv_pkg;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } ma_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_e;

  // Anything that is not an explicit byte or half encoding is a full word.
  function automatic access_size_e access_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: access_size = SZ_BYTE;
      F3_H, F3_HU: access_size = SZ_HALF;
      default:     access_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (access_size(f3))
      SZ_HALF: is_misaligned = a[0];
      SZ_WORD: is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational lane steering: store byte enables / replicated data and load extraction.
module mem_align
  import mriscv_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  always_comb begin
    wstrb     = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    byte_sh   = rdata >> {addr_lo, 3'b000};
    half_sh   = rdata >> {addr_lo[1], 4'b0000};

    case (access_size(funct3))
      SZ_BYTE: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        wstrb = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase

    case (funct3)
      F3_B:    load_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      F3_BU:   load_data = {24'h0, byte_sh[7:0]};
      F3_H:    load_data = {{16{half_sh[15]}}, half_sh[15:0]};
      F3_HU:   load_data = {16'h0, half_sh[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: req/ack data-memory handshake feeding write_back.
// Optional MEM_ACCESS_MISALIGN_TRAP_EN adds a misalign pulse instead of issuing a misaligned access.
module mem_access
  import mriscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_in,
  input  logic [31:0] next_pc_in,
  input  logic [1:0]  mem_op,
  input  logic [2:0]  funct3,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        out_valid,
  output logic [31:0] result,
  output logic [4:0]  dest_out,
  output logic [31:0] next_pc_out
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  ma_state_e   state_q, state_d;
  logic        accept, is_mem, trap, start_mem, finish;
  logic [1:0]  lo_q, lo_sel;
  logic [2:0]  f3_q, f3_sel;
  logic        load_q;
  logic [4:0]  dest_q;
  logic [31:0] npc_q;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_load;

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == ST_IDLE);
    accept    = in_ready && in_valid;
    is_mem    = (mem_op == MEM_LOAD) || (mem_op == MEM_STORE);
    trap      = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    trap      = accept && is_mem && is_misaligned(funct3, alu_result[1:0]);
`endif
    start_mem = accept && is_mem && !trap;
    finish    = (state_q == ST_WAIT) && mem_ack;
    // The aligner sees the incoming instruction in IDLE and the parked one in WAIT.
    lo_sel    = (state_q == ST_WAIT) ? lo_q : alu_result[1:0];
    f3_sel    = (state_q == ST_WAIT) ? f3_q : funct3;

    case (state_q)
      ST_IDLE: if (start_mem) state_d = ST_WAIT;
      ST_WAIT: if (mem_ack)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  mem_align u_align (
    .addr_lo    (lo_sel),
    .funct3     (f3_sel),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      out_valid   <= 1'b0;
      result      <= '0;
      dest_out    <= '0;
      next_pc_out <= RESET_PC;
      lo_q        <= '0;
      f3_q        <= '0;
      load_q      <= 1'b0;
      dest_q      <= '0;
      npc_q       <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      misalign    <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      dest_out  <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      misalign  <= 1'b0;
`endif
      if (start_mem) begin
        mem_req   <= 1'b1;
        mem_we    <= (mem_op == MEM_STORE);
        mem_addr  <= {alu_result[31:2], 2'b00};
        mem_wdata <= al_wdata;
        mem_wstrb <= (mem_op == MEM_STORE) ? al_wstrb : 4'b0000;
        lo_q      <= alu_result[1:0];
        f3_q      <= funct3;
        load_q    <= (mem_op == MEM_LOAD);
        dest_q    <= dest_in;
        npc_q     <= next_pc_in;
      end else if (trap) begin
        out_valid   <= 1'b1;
        result      <= alu_result;
        next_pc_out <= next_pc_in;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        misalign    <= 1'b1;
`endif
      end else if (accept) begin
        out_valid   <= 1'b1;
        result      <= alu_result;
        dest_out    <= dest_in;
        next_pc_out <= next_pc_in;
      end

      if (finish) begin
        mem_req     <= 1'b0;
        mem_we      <= 1'b0;
        mem_wstrb   <= 4'b0000;
        out_valid   <= 1'b1;
        next_pc_out <= npc_q;
        if (load_q) begin
          result   <= al_load;
          dest_out <= dest_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized transactions vs. a byte-level model.
module tb_mem_access;

  localparam logic [31:0] RPC = 32'h0000_1000;

  logic        clk, reset;
  logic        in_valid, in_ready;
  logic [31:0] alu_result, store_data, next_pc_in;
  logic [4:0]  dest_in;
  logic [1:0]  mem_op;
  logic [2:0]  funct3;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        out_valid;
  logic [31:0] result, next_pc_out;
  logic [4:0]  dest_out;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_result;
  logic [31:0] exp_npc;

  mem_access #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_result  (alu_result),
    .store_data  (store_data),
    .dest_in     (dest_in),
    .next_pc_in  (next_pc_in),
    .mem_op      (mem_op),
    .funct3      (funct3),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .out_valid   (out_valid),
    .result      (result),
    .dest_out    (dest_out),
    .next_pc_out (next_pc_out)
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    ,
    .misalign    (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: access size in bytes, aligned down to that size.
  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input int a);
    int sz = size_of(f3);
    int off = a - (a % sz);
    logic [3:0] s = '0;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + sz) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int sz = size_of(f3);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++)
      w[8*i +: 8] = sd[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int a, input logic [31:0] rd);
    int sz = size_of(f3);
    int off = a - (a % sz);
    longint unsigned mask;
    longint unsigned v;
    if (sz == 4) return rd;
    mask = (64'd1 << (8 * sz)) - 1;
    v = (longint'(rd) >> (8 * off)) & mask;
    if (f3[2] == 1'b0 && v[8*sz-1]) v = v | (~mask);
    return v[31:0];
  endfunction

  function automatic logic model_misaligned(input logic [2:0] f3, input int a);
    return (a % size_of(f3)) != 0;
  endfunction

  // Called on a negedge in the cycle after the previous out_valid pulse; returns on the same phase.
  task automatic run_txn(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] dst, input logic [31:0] npc,
                         input logic [31:0] rd, input int dly);
    logic is_mem, is_trap;
    is_mem  = (op == 2'b01) || (op == 2'b10);
    is_trap = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    is_trap = is_mem && model_misaligned(f3, int'(addr[1:0]));
    check("gap_misalign", misalign, 1'b0);
`endif
    check("gap_out_valid", out_valid, 1'b0);
    check("gap_dest", dest_out, 5'd0);
    check("gap_result", result, exp_result);
    check("gap_npc", next_pc_out, exp_npc);
    check("gap_in_ready", in_ready, 1'b1);

    in_valid = 1'b1; mem_op = op; funct3 = f3; alu_result = addr;
    store_data = sd; dest_in = dst; next_pc_in = npc;
    @(negedge clk);
    in_valid = 1'b0;

    if (!is_mem || is_trap) begin
      exp_result = addr;
      exp_npc    = npc;
      check("imm_out_valid", out_valid, 1'b1);
      check("imm_mem_req", mem_req, 1'b0);
      check("imm_result", result, exp_result);
      check("imm_dest", dest_out, is_trap ? 5'd0 : dst);
      check("imm_npc", next_pc_out, exp_npc);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      check("imm_misalign", misalign, is_trap);
`endif
    end else begin
      for (int k = 0; k <= dly; k++) begin
        check("wait_req", mem_req, 1'b1);
        check("wait_we", mem_we, op == 2'b10);
        check("wait_addr", mem_addr, {addr[31:2], 2'b00});
        check("wait_strb", mem_wstrb, (op == 2'b10) ? model_strb(f3, int'(addr[1:0])) : 4'b0000);
        if (op == 2'b10) check("wait_wdata", mem_wdata, model_wdata(f3, sd));
        check("wait_in_ready", in_ready, 1'b0);
        check("wait_out_valid", out_valid, 1'b0);
        if (k == dly) begin
          mem_ack = 1'b1;
          mem_rdata = rd;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = $urandom;
      end
      if (op == 2'b01) exp_result = model_load(f3, int'(addr[1:0]), rd);
      exp_npc = npc;
      check("done_out_valid", out_valid, 1'b1);
      check("done_mem_req", mem_req, 1'b0);
      check("done_result", result, exp_result);
      check("done_dest", dest_out, (op == 2'b01) ? dst : 5'd0);
      check("done_npc", next_pc_out, exp_npc);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [1:0]  op;
    logic [2:0]  f3;
    reset = 1'b1; in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    alu_result = '0; store_data = '0; dest_in = '0; next_pc_in = '0;
    mem_op = 2'b00; funct3 = 3'b000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_result = 32'h0;
    exp_npc    = RPC;

    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_wstrb", mem_wstrb, 4'b0000);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_npc", next_pc_out, RPC);
    check("rst_in_ready", in_ready, 1'b1);

    // Pass-through op, then the cycle after its pulse is checked at the next entry.
    run_txn(2'b00, 3'b010, 32'd1000, 32'h0, 5'd5, 32'd8, 32'h0, 0);
    check("none_after_dest", dest_out, 5'd0);
    check("none_after_npc", next_pc_out, 32'd8);

    // SB to the top byte lane with a 3-cycle ack delay.
    run_txn(2'b10, 3'b000, 32'h103, 32'h0000_00A5, 5'd3, 32'h20, 32'h0, 3);
    check("sb_result_held", result, 32'd1000);

    run_txn(2'b01, 3'b000, 32'h102, 32'h0, 5'd6, 32'h24, 32'h0080_FF00, 0);
    check("lb_value", result, 32'hFFFF_FF80);
    run_txn(2'b01, 3'b100, 32'h102, 32'h0, 5'd6, 32'h28, 32'h0080_FF00, 1);
    check("lbu_value", result, 32'h0000_0080);
    run_txn(2'b01, 3'b001, 32'h102, 32'h0, 5'd7, 32'h2C, 32'h8000_0000, 2);
    check("lh_value", result, 32'hFFFF_8000);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    run_txn(2'b01, 3'b010, 32'h101, 32'h0, 5'd9, 32'h30, 32'h0, 0);
    check("trap_result", result, 32'h101);
`endif

    // Second op held on in_valid while the first waits for ack.
    in_valid = 1'b1; mem_op = 2'b01; funct3 = 3'b010; alu_result = 32'h200;
    dest_in = 5'd7; next_pc_in = 32'h44;
    @(negedge clk);
    check("ord_req", mem_req, 1'b1);
    mem_op = 2'b00; alu_result = 32'h1234; dest_in = 5'd9; next_pc_in = 32'h48;
    check("ord_in_ready", in_ready, 1'b0);
    @(negedge clk);
    check("ord_no_merge", out_valid, 1'b0);
    check("ord_req_held", mem_req, 1'b1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_ack = 1'b0;
    check("ord_first_valid", out_valid, 1'b1);
    check("ord_first_result", result, 32'hCAFE_F00D);
    check("ord_first_dest", dest_out, 5'd7);
    check("ord_first_npc", next_pc_out, 32'h44);
    @(negedge clk);
    in_valid = 1'b0;
    check("ord_second_valid", out_valid, 1'b1);
    check("ord_second_result", result, 32'h1234);
    check("ord_second_dest", dest_out, 5'd9);
    check("ord_second_npc", next_pc_out, 32'h48);
    @(negedge clk);
    exp_result = 32'h1234;
    exp_npc    = 32'h48;

    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      f3 = 3'($urandom_range(0, 7));
      if (op == 2'b10 && (f3 == 3'b100 || f3 == 3'b101)) f3 = 3'b010;
      run_txn(op, f3, $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom, $urandom,
              int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a wait, then a late ack.
    in_valid = 1'b1; mem_op = 2'b10; funct3 = 3'b010; alu_result = 32'h300;
    store_data = 32'h1111_2222; dest_in = 5'd4; next_pc_in = 32'h88;
    @(negedge clk);
    in_valid = 1'b0;
    check("rw_req_before", mem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rw_req", mem_req, 1'b0);
    check("rw_npc", next_pc_out, RPC);
    check("rw_dest", dest_out, 5'd0);
    check("rw_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("late_ack_valid", out_valid, 1'b0);
    check("late_ack_req", mem_req, 1'b0);
    check("late_ack_npc", next_pc_out, RPC);
    check("late_ack_result", result, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
